spi_rx_pkt_writer: RTL

//  Packet front-end between the SPI slave byte receiver and the return-capable async write FIFO.

---
 rtl/spi_rx_pkt_writer.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/spi_rx_pkt_writer.sv
// spi_rx_pkt_writer
//   Packet front-end between an SPI slave byte receiver and a return-capable write FIFO.
//   Each chip-select frame is: header, LEN, 4*LEN payload bytes, XOR checksum.
//   Payload bytes are packed little-endian into 32-bit words and written speculatively;
//   the frame is then committed (WR_SUCC) or rewound (WR_FAIL) in the FIFO.
//
// Ports
//   CLK_I               clock (byte domain == FIFO write domain)
//   RST_I               synchronous active-high reset
//   BYTE_VALID_I        one received byte per high cycle
//   BYTE_DATA_I[7:0]    received byte
//   FRAME_END_I         1-cycle pulse on chip-select deassert
//   FIFO_WR_EN_O        FIFO write strobe (registered)
//   FIFO_WR_DATA_O      packed word, first byte in [7:0]
//   FIFO_WR_EN_VALID_I  FIFO accepted the write strobed this cycle
//   FIFO_WR_FULL_I      FIFO (prog-)full
//   FIFO_WR_SUCC_O      1-cycle commit pulse
//   FIFO_WR_FAIL_O      1-cycle rewind pulse
//   ERR_CODE_O          verdict of last frame (0 ok,1 hdr,2 len,3 trunc,4 ovf,5 csum,6 rej)
//   FRAME_OK_CNT_O      committed frames, wrapping
//   FRAME_ERR_CNT_O     errored frames, wrapping
//   BUSY_O              high whenever not idle
module spi_rx_pkt_writer #(
  parameter logic [7:0]  C_HEADER          = 8'hA5,
  parameter int unsigned C_MAX_WORDS       = 64,
  parameter int unsigned C_DBG_COUNT_WIDTH = 16
) (
  input  logic                         CLK_I,
  input  logic                         RST_I,
  input  logic                         BYTE_VALID_I,
  input  logic [7:0]                   BYTE_DATA_I,
  input  logic                         FRAME_END_I,
  output logic                         FIFO_WR_EN_O,
  output logic [31:0]                  FIFO_WR_DATA_O,
  input  logic                         FIFO_WR_EN_VALID_I,
  input  logic                         FIFO_WR_FULL_I,
  output logic                         FIFO_WR_SUCC_O,
  output logic                         FIFO_WR_FAIL_O,
  output logic [2:0]                   ERR_CODE_O,
  output logic [C_DBG_COUNT_WIDTH-1:0] FRAME_OK_CNT_O,
  output logic [C_DBG_COUNT_WIDTH-1:0] FRAME_ERR_CNT_O,
  output logic                         BUSY_O
);

  localparam logic [7:0] MaxLen = 8'(C_MAX_WORDS);
  localparam logic [C_DBG_COUNT_WIDTH-1:0] CntOne = {{(C_DBG_COUNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    StIdle, StLen, StPayload, StCsum, StWaitEnd, StDiscard
  } state_e;

  typedef enum logic [2:0] {
    ErrOk    = 3'd0,
    ErrHdr   = 3'd1,
    ErrLen   = 3'd2,
    ErrTrunc = 3'd3,
    ErrOvf   = 3'd4,
    ErrCsum  = 3'd5,
    ErrRej   = 3'd6
  } err_e;

  state_e                       state_q;
  err_e                         err_code_q;
  logic [7:0]                   len_q;
  logic [7:0]                   word_cnt_q;
  logic [1:0]                   lane_q;
  logic [7:0]                   csum_q;
  logic [31:0]                  word_q;
  logic                         wr_en_q;
  logic [31:0]                  wr_data_q;
  logic                         succ_q;
  logic                         fail_q;
  logic [C_DBG_COUNT_WIDTH-1:0] ok_cnt_q;
  logic [C_DBG_COUNT_WIDTH-1:0] err_cnt_q;

  logic rej;
  logic len_bad;
  logic word_last;

  // The FIFO refused last cycle's write; only meaningful while the frame is still live.
  assign rej       = wr_en_q && !FIFO_WR_EN_VALID_I &&
                     ((state_q == StPayload) || (state_q == StCsum));
  assign len_bad   = (BYTE_DATA_I == 8'd0) || (BYTE_DATA_I > MaxLen);
  assign word_last = ((word_cnt_q + 8'd1) == len_q);

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q    <= StIdle;
      err_code_q <= ErrOk;
      len_q      <= 8'd0;
      word_cnt_q <= 8'd0;
      lane_q     <= 2'd0;
      csum_q     <= 8'd0;
      word_q     <= 32'd0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= 32'd0;
      succ_q     <= 1'b0;
      fail_q     <= 1'b0;
      ok_cnt_q   <= '0;
      err_cnt_q  <= '0;
    end else begin
      wr_en_q <= 1'b0;
      succ_q  <= 1'b0;
      fail_q  <= 1'b0;

      if (rej) begin
        // Takes priority over anything else seen this cycle, so a frame whose last word
        // was refused can never also be committed.
        fail_q     <= 1'b1;
        err_code_q <= ErrRej;
        err_cnt_q  <= err_cnt_q + CntOne;
        state_q    <= FRAME_END_I ? StIdle : StDiscard;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (BYTE_VALID_I) begin
              if (BYTE_DATA_I == C_HEADER) begin
                if (FRAME_END_I) begin
                  fail_q     <= 1'b1;
                  err_code_q <= ErrTrunc;
                  err_cnt_q  <= err_cnt_q + CntOne;
                end else begin
                  state_q <= StLen;
                end
              end else begin
                // Nothing has been written yet, so there is nothing to rewind.
                err_code_q <= ErrHdr;
                err_cnt_q  <= err_cnt_q + CntOne;
                state_q    <= FRAME_END_I ? StIdle : StDiscard;
              end
            end
          end

          StLen: begin
            if (BYTE_VALID_I && len_bad) begin
              fail_q     <= 1'b1;
              err_code_q <= ErrLen;
              err_cnt_q  <= err_cnt_q + CntOne;
              state_q    <= FRAME_END_I ? StIdle : StDiscard;
            end else if (FRAME_END_I) begin
              fail_q     <= 1'b1;
              err_code_q <= ErrTrunc;
              err_cnt_q  <= err_cnt_q + CntOne;
              state_q    <= StIdle;
            end else if (BYTE_VALID_I) begin
              len_q      <= BYTE_DATA_I;
              word_cnt_q <= 8'd0;
              lane_q     <= 2'd0;
              csum_q     <= 8'd0;
              state_q    <= StPayload;
            end
          end

          StPayload: begin
            if (BYTE_VALID_I) begin
              csum_q <= csum_q ^ BYTE_DATA_I;
              lane_q <= lane_q + 2'd1;
              word_q[{lane_q, 3'b000} +: 8] <= BYTE_DATA_I;
            end
            if (BYTE_VALID_I && (lane_q == 2'd3) && FIFO_WR_FULL_I) begin
              fail_q     <= 1'b1;
              err_code_q <= ErrOvf;
              err_cnt_q  <= err_cnt_q + CntOne;
              state_q    <= FRAME_END_I ? StIdle : StDiscard;
            end else if (FRAME_END_I) begin
              // A word completing in this cycle is dropped: its write would otherwise
              // collide with the rewind pulse, and the frame is discarded anyway.
              fail_q     <= 1'b1;
              err_code_q <= ErrTrunc;
              err_cnt_q  <= err_cnt_q + CntOne;
              state_q    <= StIdle;
            end else if (BYTE_VALID_I && (lane_q == 2'd3)) begin
              wr_en_q    <= 1'b1;
              wr_data_q  <= {BYTE_DATA_I, word_q[23:0]};
              word_cnt_q <= word_cnt_q + 8'd1;
              if (word_last) begin
                state_q <= StCsum;
              end
            end
          end

          StCsum: begin
            if (BYTE_VALID_I) begin
              if (BYTE_DATA_I == csum_q) begin
                succ_q     <= 1'b1;
                err_code_q <= ErrOk;
                ok_cnt_q   <= ok_cnt_q + CntOne;
                state_q    <= FRAME_END_I ? StIdle : StWaitEnd;
              end else begin
                fail_q     <= 1'b1;
                err_code_q <= ErrCsum;
                err_cnt_q  <= err_cnt_q + CntOne;
                state_q    <= FRAME_END_I ? StIdle : StDiscard;
              end
            end else if (FRAME_END_I) begin
              fail_q     <= 1'b1;
              err_code_q <= ErrTrunc;
              err_cnt_q  <= err_cnt_q + CntOne;
              state_q    <= StIdle;
            end
          end

          StWaitEnd, StDiscard: begin
            if (FRAME_END_I) begin
              state_q <= StIdle;
            end
          end

          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign FIFO_WR_EN_O    = wr_en_q;
  assign FIFO_WR_DATA_O  = wr_data_q;
  assign FIFO_WR_SUCC_O  = succ_q;
  assign FIFO_WR_FAIL_O  = fail_q;
  assign ERR_CODE_O      = err_code_q;
  assign FRAME_OK_CNT_O  = ok_cnt_q;
  assign FRAME_ERR_CNT_O = err_cnt_q;
  assign BUSY_O          = (state_q != StIdle);

endmodule
